line_sequencer: RTL and testbench

LINE_SEQUENCER -- requirements
Module: line_sequencer

---
 rtl/line_sequencer.sv | 119 +++++++++++
 tb/tb_line_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/line_sequencer.sv
// line_sequencer: walks a stored polyline and hands one segment at a time to a line drawer,
// optionally preceded by a raster clear sweep.
module line_sequencer #(
   parameter int N_PTS = 8,
   parameter int CW    = 11,
   parameter int X_MAX = 639,
   parameter int Y_MAX = 479
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     wr_en,
   input  logic [$clog2(N_PTS)-1:0] wr_addr,
   input  logic [CW-1:0]            wr_x,
   input  logic [CW-1:0]            wr_y,
   input  logic                     start,
   input  logic [4:0]               num_pts,
   input  logic                     closed,
   input  logic                     clear,
   input  logic                     erase,
   input  logic                     line_done,
   output logic [CW-1:0]            x0,
   output logic [CW-1:0]            y0,
   output logic [CW-1:0]            x1,
   output logic [CW-1:0]            y1,
   output logic                     line_start,
   output logic                     color,
   output logic [CW-1:0]            clr_x,
   output logic [CW-1:0]            clr_y,
   output logic                     clr_we,
   output logic                     busy,
   output logic                     frame_done
);
   localparam int AW = $clog2(N_PTS);
   typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, WAIT, FIN} state_t;
   state_t state, state_nx;
   logic [CW-1:0] tx [N_PTS];
   logic [CW-1:0] ty [N_PTS];
   logic [4:0] n_q, seg_q, k_q, k_nx, k_inc, n_clamp, seg_in, n_sel, seg_sel;
   logic       erase_q, erase_sel, clr_last, load;
   logic [AW-1:0] a0, a1;
   logic [CW-1:0] cx, cy;
   assign n_clamp   = (num_pts > 5'(N_PTS)) ? 5'(N_PTS) : num_pts;
   assign seg_in    = (n_clamp < 5'd2) ? 5'd0 : n_clamp - 5'd1 + {4'd0, closed};
   assign n_sel     = (state == IDLE) ? n_clamp : n_q;
   assign seg_sel   = (state == IDLE) ? seg_in : seg_q;
   assign erase_sel = (state == IDLE) ? erase : erase_q;
   assign clr_last  = (cx == CW'(X_MAX)) && (cy == CW'(Y_MAX));
   assign line_start = (state == ISSUE) && (seg_q != 5'd0);
   assign clr_we     = (state == CLEAR);
   assign frame_done = (state == FIN);
   assign busy       = (state != IDLE);
   assign clr_x      = cx;
   assign clr_y      = cy;
   always_comb begin
      state_nx = state;
      k_nx     = k_q;
      case (state)
         IDLE:  if (start) begin
            k_nx     = 5'd0;
            state_nx = clear ? CLEAR : ISSUE;
         end
         CLEAR: if (clr_last) state_nx = (seg_q == 5'd0) ? FIN : ISSUE;
         ISSUE: state_nx = (seg_q == 5'd0) ? FIN : WAIT;
         WAIT:  if (line_done) begin
            k_nx     = k_q + 5'd1;
            state_nx = (k_nx < seg_q) ? ISSUE : FIN;
         end
         FIN:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // Endpoints are captured on the edge entering ISSUE so they are valid alongside line_start.
   assign k_inc = k_nx + 5'd1;
   assign a0    = AW'(k_nx);
   assign a1    = (k_inc >= n_sel) ? '0 : AW'(k_inc);
   assign load  = (state_nx == ISSUE) && (state != ISSUE) && (seg_sel != 5'd0);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         k_q     <= '0;
         n_q     <= '0;
         seg_q   <= '0;
         erase_q <= 1'b0;
         cx      <= '0;
         cy      <= '0;
         x0      <= '0;
         y0      <= '0;
         x1      <= '0;
         y1      <= '0;
         color   <= 1'b0;
      end else begin
         state <= state_nx;
         k_q   <= k_nx;
         if (state == IDLE && start) begin
            n_q     <= n_clamp;
            seg_q   <= seg_in;
            erase_q <= erase;
         end
         if (state == CLEAR) begin
            cx <= (cx == CW'(X_MAX)) ? '0 : cx + 1'b1;
            cy <= (cx != CW'(X_MAX)) ? cy : (cy == CW'(Y_MAX)) ? '0 : cy + 1'b1;
         end
         if (load) begin
            x0    <= tx[a0];
            y0    <= ty[a0];
            x1    <= tx[a1];
            y1    <= ty[a1];
            color <= ~erase_sel;
         end
      end
   end
   // The point table has no reset so its contents survive reset_n.
   always_ff @(posedge clk) begin
      if (state == IDLE && wr_en && ({1'b0, wr_addr} < (AW + 1)'(N_PTS))) begin
         tx[wr_addr] <= wr_x;
         ty[wr_addr] <= wr_y;
      end
   end
endmodule

// File: tb/tb_line_sequencer.sv
// tb_line_sequencer: randomized frames against a segment-list reference model.
module tb_line_sequencer;
   logic clk = 1'b0, reset_n = 1'b0;
   logic wr_en = 1'b0, start = 1'b0, closed = 1'b0, clear = 1'b0, erase = 1'b0, line_done = 1'b0;
   logic [2:0] wr_addr = '0;
   logic [10:0] wr_x = '0, wr_y = '0;
   logic [4:0] num_pts = '0;
   logic [10:0] x0, y0, x1, y1, clr_x, clr_y;
   logic line_start, color, clr_we, busy, frame_done;
   logic [10:0] mtx [8];
   logic [10:0] mty [8];
   int n_chk = 0, n_fail = 0;

   line_sequencer #(.N_PTS(8), .CW(11), .X_MAX(3), .Y_MAX(1)) dut (
      .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
      .start(start), .num_pts(num_pts), .closed(closed), .clear(clear), .erase(erase),
      .line_done(line_done), .x0(x0), .y0(y0), .x1(x1), .y1(y1), .line_start(line_start),
      .color(color), .clr_x(clr_x), .clr_y(clr_y), .clr_we(clr_we), .busy(busy),
      .frame_done(frame_done));

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input int x, input int y);
      wr_en = 1'b1; wr_addr = 3'(a); wr_x = 11'(x); wr_y = 11'(y);
      tick();
      wr_en = 1'b0;
      mtx[a] = 11'(x);
      mty[a] = 11'(y);
   endtask

   task automatic run_frame(input int n, input bit cl, input bit clr, input bit er);
      int nn, segs, a, b, d;
      nn = (n > 8) ? 8 : n;
      segs = (nn < 2) ? 0 : nn - 1 + int'(cl);
      a = 0; b = 0;
      num_pts = 5'(n); closed = cl; clear = clr; erase = er; start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      if (clr)
         for (int yy = 0; yy <= 1; yy++)
            for (int xx = 0; xx <= 3; xx++) begin
               chk("clr_we", {clr_we, line_start, frame_done}, 3'b100);
               chk("clr_xy", {clr_x, clr_y}, {11'(xx), 11'(yy)});
               tick();
            end
      if (segs == 0 && !clr) begin
         chk("no_issue", {line_start, frame_done, busy}, 3'b001);
         tick();
      end
      for (int k = 0; k < segs; k++) begin
         a = k;
         b = (k + 1) % nn;
         chk("issue", {line_start, clr_we, frame_done}, 3'b100);
         chk("seg", {x0, y0, x1, y1, color}, {mtx[a], mty[a], mtx[b], mty[b], ~er});
         tick();
         d = $urandom_range(0, 3);
         for (int j = 0; j < d; j++) begin
            chk("wait", {line_start, busy}, 2'b01);
            if (j == 0) begin
               start = 1'b1; wr_en = 1'b1; wr_addr = 3'($urandom);
               wr_x = 11'($urandom); wr_y = 11'($urandom);
            end
            tick();
            start = 1'b0; wr_en = 1'b0;
         end
         line_done = 1'b1;
         tick();
         line_done = 1'b0;
      end
      chk("fin", {frame_done, line_start, clr_we, busy}, 4'b1001);
      tick();
      chk("idle", {frame_done, busy}, 2'b00);
      if (segs > 0) chk("hold", {x0, y0, x1, y1, color}, {mtx[a], mty[a], mtx[b], mty[b], ~er});
      line_done = 1'b1;
      tick();
      line_done = 1'b0;
      chk("ld_idle", {busy, line_start, frame_done}, 3'b000);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ctl", {line_start, clr_we, frame_done, busy, color}, 5'b0);
      chk("rst_xy", {x0, y0, x1, y1, clr_x}, 55'b0);
      reset_n = 1'b1;
      tick();
      wr(0, 10, 20); wr(1, 50, 20); wr(2, 50, 60);
      run_frame(3, 1'b0, 1'b0, 1'b0);
      run_frame(3, 1'b1, 1'b0, 1'b0);
      run_frame(3, 1'b0, 1'b0, 1'b1);
      run_frame(2, 1'b0, 1'b1, 1'b0);
      run_frame(1, 1'b0, 1'b0, 1'b0);
      // reset during the wait for segment 2
      num_pts = 5'd3; closed = 1'b0; clear = 1'b0; erase = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      line_done = 1'b1;
      tick();
      line_done = 1'b0;
      chk("seg2_issue", line_start, 1);
      tick();
      #2 reset_n = 1'b0;
      #1;
      chk("async_ctl", {line_start, clr_we, frame_done, busy, color}, 5'b0);
      chk("async_xy", {x0, y0, x1, y1}, 44'b0);
      tick();
      reset_n = 1'b1;
      tick();
      chk("post_rst_idle", busy, 0);
      run_frame(3, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) wr(i, $urandom_range(0, 2047), $urandom_range(0, 2047));
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 2) == 0) wr($urandom_range(0, 7), $urandom_range(0, 2047), $urandom_range(0, 2047));
         run_frame($urandom_range(0, 31), 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
